// File: rtl/ex_stage.sv
// ex_stage: execute stage holding one uop behind valid/ready, evaluating it through alu
// and resolving BRANCH/JAL/JALR into a single-cycle front-end redirect.
package liang_pkg;
   localparam int XLEN = 32;
   typedef enum logic [3:0] {
      ALU, ALUI, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE
   } fu_op_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fu_op_t          fu_op;
      logic [3:0]      fu_func;
   } uop_info_t;
   localparam logic [3:0] F_ADD  = 4'd0;
   localparam logic [3:0] F_SUB  = 4'd1;
   localparam logic [3:0] F_SLL  = 4'd2;
   localparam logic [3:0] F_SLT  = 4'd3;
   localparam logic [3:0] F_SLTU = 4'd4;
   localparam logic [3:0] F_XOR  = 4'd5;
   localparam logic [3:0] F_SRL  = 4'd6;
   localparam logic [3:0] F_SRA  = 4'd7;
   localparam logic [3:0] F_OR   = 4'd8;
   localparam logic [3:0] F_AND  = 4'd9;
   localparam logic [3:0] F_BEQ  = 4'd0;
   localparam logic [3:0] F_BNE  = 4'd1;
   localparam logic [3:0] F_BLT  = 4'd4;
   localparam logic [3:0] F_BGE  = 4'd5;
   localparam logic [3:0] F_BLTU = 4'd6;
   localparam logic [3:0] F_BGEU = 4'd7;
endpackage

module alu
   import liang_pkg::*;
(
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  uop_info_t       uop_info_i,
   output logic [XLEN-1:0] res_o,
   output logic            jump_o
);
   logic [XLEN-1:0]         w_a;
   logic [XLEN-1:0]         w_b;
   logic [3:0]              w_func;
   logic [$clog2(XLEN)-1:0] w_sh;
   logic                    w_eq;
   logic                    w_lt;
   logic                    w_ltu;
   fu_op_t                  w_op;
   assign w_op = uop_info_i.fu_op;
   assign w_a = (w_op == AUIPC || w_op == JAL || w_op == JALR) ? uop_info_i.pc : rs1_i;
   assign w_b = (w_op == ALU || w_op == BRANCH) ? rs2_i :
                (w_op == JAL || w_op == JALR) ? XLEN'(4) : uop_info_i.imm;
   // Only register/immediate ALU ops honour fu_func; everything else is an add.
   assign w_func = (w_op == ALU || w_op == ALUI) ? uop_info_i.fu_func : F_ADD;
   assign w_sh  = w_b[$clog2(XLEN)-1:0];
   assign w_eq  = w_a == w_b;
   assign w_lt  = $signed(w_a) < $signed(w_b);
   assign w_ltu = w_a < w_b;
   always_comb begin
      res_o = w_a + w_b;
      case (w_func)
         F_SUB:   res_o = w_a - w_b;
         F_SLL:   res_o = w_a << w_sh;
         F_SLT:   res_o = XLEN'(w_lt);
         F_SLTU:  res_o = XLEN'(w_ltu);
         F_XOR:   res_o = w_a ^ w_b;
         F_SRL:   res_o = w_a >> w_sh;
         F_SRA:   res_o = XLEN'($signed(w_a) >>> w_sh);
         F_OR:    res_o = w_a | w_b;
         F_AND:   res_o = w_a & w_b;
         default: res_o = w_a + w_b;
      endcase
      if (w_op == LUI) res_o = uop_info_i.imm;
   end
   always_comb begin
      jump_o = 1'b0;
      case (uop_info_i.fu_func)
         F_BEQ:   jump_o = w_eq;
         F_BNE:   jump_o = ~w_eq;
         F_BLT:   jump_o = w_lt;
         F_BGE:   jump_o = ~w_lt;
         F_BLTU:  jump_o = w_ltu;
         F_BGEU:  jump_o = ~w_ltu;
         default: jump_o = 1'b0;
      endcase
      if (w_op != BRANCH) jump_o = 1'b0;
   end
endmodule

module ex_stage
   import liang_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  uop_info_t       in_uop_i,
   input  logic [XLEN-1:0] in_rs1_i,
   input  logic [XLEN-1:0] in_rs2_i,
   input  logic [4:0]      in_rd_i,
   input  logic            in_rd_wen_i,
   output logic            wb_valid_o,
   input  logic            wb_ready_i,
   output logic [XLEN-1:0] wb_pc_o,
   output uop_info_t       wb_uop_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic [XLEN-1:0] wb_rs2_o,
   output logic [4:0]      wb_rd_o,
   output logic            wb_rd_wen_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o
);
   logic            r_valid;
   uop_info_t       r_uop;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic [4:0]      r_rd;
   logic            r_rd_wen;
   logic            w_in_fire;
   logic            w_wb_fire;
   logic            w_jump;
   logic            w_taken;
   logic [XLEN-1:0] w_alu_res;
   logic [XLEN-1:0] w_sum;
   logic [XLEN-1:0] w_target;

   alu u_alu (
      .rs1_i      (r_rs1),
      .rs2_i      (r_rs2),
      .uop_info_i (r_uop),
      .res_o      (w_alu_res),
      .jump_o     (w_jump)
   );

   // Reset also masks the held entry so nothing leaks out while rst_i is high.
   assign wb_valid_o = r_valid & ~flush_i & ~rst_i;
   assign w_wb_fire  = wb_valid_o & wb_ready_i;
   assign w_taken    = (r_uop.fu_op == BRANCH & w_jump) | r_uop.fu_op == JAL | r_uop.fu_op == JALR;
   assign w_sum      = (r_uop.fu_op == JALR ? r_rs1 : r_uop.pc) + r_uop.imm;
   assign w_target   = r_uop.fu_op == JALR ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
   assign redirect_o    = w_wb_fire & w_taken;
   assign redirect_pc_o = redirect_o ? w_target : '0;
   assign in_ready_o = (~r_valid | wb_ready_i) & ~redirect_o & ~flush_i & ~rst_i;
   assign w_in_fire  = in_valid_i & in_ready_o;

   assign wb_pc_o     = r_uop.pc;
   assign wb_uop_o    = r_uop;
   assign wb_data_o   = w_alu_res;
   assign wb_rs2_o    = r_rs2;
   assign wb_rd_o     = r_rd;
   assign wb_rd_wen_o = r_rd_wen & (r_rd != 5'd0) & (r_uop.fu_op != BRANCH);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid  <= 1'b0;
         r_uop    <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_rd     <= '0;
         r_rd_wen <= 1'b0;
      end else begin
         if (flush_i) r_valid <= 1'b0;
         else if (w_in_fire) r_valid <= 1'b1;
         else if (w_wb_fire) r_valid <= 1'b0;
         if (w_in_fire) begin
            r_uop    <= in_uop_i;
            r_rs1    <= in_rs1_i;
            r_rs2    <= in_rs2_i;
            r_rd     <= in_rd_i;
            r_rd_wen <= in_rd_wen_i;
         end
      end
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage of the NPC core. It sits between decode/operand-read and writeback/LSU. It registers one decoded uop plus its operands behind a valid/ready handshake, evaluates it through an `alu` instance, and presents the result downstream. It resolves control flow (BRANCH/JAL/JALR) and generates a one-cycle redirect to the front end.

## Interface
Parameters:
- XLEN, from liang_pkg (32): datapath width.

Ports (all types from liang_pkg):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  kill the uop held in this stage (e.g. trap/commit flush).
- in_valid_i  in  1  upstream uop valid.
- in_ready_o  out  1  stage can accept a uop this cycle.
- in_uop_i  in  uop_info_t  decoded uop (pc, imm, fu_op, fu_func).
- in_rs1_i  in  XLEN  operand rs1 value.
- in_rs2_i  in  XLEN  operand rs2 value.
- in_rd_i  in  5  destination register index.
- in_rd_wen_i  in  1  uop writes rd.
- wb_valid_o  out  1  result valid.
- wb_ready_i  in  1  downstream accepts the result.
- wb_pc_o  out  XLEN  pc of the held uop.
- wb_uop_o  out  uop_info_t  held uop, passed through for LSU decode.
- wb_data_o  out  XLEN  alu_res (LOAD/STORE: effective address; JAL/JALR: pc+4).
- wb_rs2_o  out  XLEN  held rs2 (store data).
- wb_rd_o  out  5  held rd.
- wb_rd_wen_o  out  1  held rd write enable, forced 0 when rd==0.
- redirect_o  out  1  control-flow redirect pulse.
- redirect_pc_o  out  XLEN  redirect target.

## Operation
- State: one entry, consisting of ex_valid plus registered uop, rs1, rs2, rd, rd_wen. Feeds `alu` (rs1_i/rs2_i/uop_info_i) combinationally from the registered fields.
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - wb_fire = wb_valid_o & wb_ready_i.
  - wb_valid_o = ex_valid & ~flush_i.
- Acceptance: in_ready_o = (~ex_valid | wb_ready_i) & ~redirect_o & ~flush_i. This gives full throughput of one uop per cycle with back-to-back fire.
- Next state, by priority:
  - rst_i: ex_valid←0, payload←0.
  - flush_i: ex_valid←0.
  - in_fire: load the entry, ex_valid←1.
  - wb_fire: ex_valid←0.
  - Otherwise hold.
- Payload registers load only on in_fire and hold while stalled (wb_valid_o & ~wb_ready_i). Outputs stay stable under stall.
- Taken decision:
  - taken = (fu_op==BRANCH & alu.jump_o) | fu_op==JAL | fu_op==JALR.
- Target, computed by a dedicated adder that wraps mod 2^XLEN:
  - BRANCH and JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - No misalignment check; bit 1 of the target passes through unchanged.
- redirect_o = wb_fire & taken. It is a single-cycle pulse, issued in the same cycle the branch leaves. redirect_pc_o is the target. redirect_pc_o is 0 whenever redirect_o=0.
- Wrong-path blocking: while redirect_o=1, in_ready_o=0, so the wrong-path uop offered that cycle is not captured. Upstream discards its own state on redirect_o.
- Not-taken branches: wb_rd_wen_o=0 (BRANCH never writes). No redirect.
- Flush: flush_i suppresses wb_valid_o, redirect_o and in_ready_o in the same cycle. If flush_i and in_valid_i coincide, the input is not accepted.

## Timing
- Reset values:
  - in_ready_o: 1 after reset deasserts (0 while rst_i is high).
  - wb_valid_o: 0.
  - redirect_o: 0.
  - redirect_pc_o: 0.
  - All wb_* payload outputs: 0.
- Latency: a uop accepted at edge N appears on wb_valid_o in cycle N+1.
- Redirect: the redirect is visible in the cycle of wb_fire. The first correct-path uop can be accepted one cycle after that.
- Stall: with wb_ready_i=0 for k cycles, wb_* outputs hold for k cycles and in_ready_o=0.
- Simultaneous wb_fire and in_fire: the new entry replaces the old; ex_valid stays 1.
- Reset mid-operation: a held uop is dropped with no output.
- Flush mid-stall: the entry is dropped at the next edge.

## Test plan
- Back-to-back ADDI: x1=5, imm=3; x1=7, imm=-1. Both with wb_ready_i=1 → wb_data_o=8 and then 6 on consecutive cycles; in_ready_o stays 1.
- Stall hold: SUB 10-3 with wb_ready_i=0 for 3 cycles → wb_data_o=7 stable for 3 cycles, in_ready_o=0. It fires on the 4th cycle.
- BEQ taken: pc=0x80000010, imm=0x20, rs1=rs2=9, with a wrong-path uop offered in the same cycle → redirect_o=1 for one cycle with redirect_pc_o=0x80000030. The wrong-path uop is not accepted and wb_rd_wen_o=0.
- BLTU not taken: rs1=0xFFFFFFFF, rs2=1 → no redirect, wb_valid_o=1.
- JALR: pc=0x80000100, rs1=0x80000203, imm=0, rd=1 → redirect_pc_o=0x80000202 and wb_data_o=0x80000104.
- Flush during stall (held JAL), then reset while valid → no wb_valid_o and no redirect_o. After reset, outputs are at their reset values and in_ready_o=1.
